// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: word/tag widths and the entry record.
package alu_rs_pkg;

    localparam int WORD_W      = 32;
    localparam int CALC_CODE_W = 4;
    localparam int IQ_ADDR_W   = 4;
    localparam int RS_SIZE_DEF = 8;

    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [CALC_CODE_W-1:0] calc_code_t;
    typedef logic [IQ_ADDR_W-1:0]   iq_addr_t;

    typedef struct packed {
        calc_code_t code;
        word_t      lhs;
        word_t      rhs;
        iq_addr_t   lhs_tag;
        iq_addr_t   rhs_tag;
        logic       lhs_rdy;
        logic       rhs_rdy;
        iq_addr_t   pos;
    } rs_entry_t;

    // An operand is woken only while still waiting on the broadcasting producer.
    function automatic logic tag_hit(input logic rdy, input iq_addr_t tag,
                                     input logic cdb_en, input iq_addr_t cdb_idx);
        return !rdy && cdb_en && (tag == cdb_idx);
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Issue, CDB and ALU-calc signals of the ALU reservation station.
interface alu_rs_if;
    import alu_rs_pkg::*;

    logic       rdy;
    logic       update_stat;
    logic       clear_flag_in;
    logic       full_out;

    logic       issue_enable_in;
    calc_code_t issue_calc_code_in;
    logic       issue_lhs_ready_in;
    word_t      issue_lhs_in;
    iq_addr_t   issue_lhs_tag_in;
    logic       issue_rhs_ready_in;
    word_t      issue_rhs_in;
    iq_addr_t   issue_rhs_tag_in;
    iq_addr_t   issue_pos_in_iq_in;

    logic       cdb_enable_in;
    iq_addr_t   cdb_iq_idx_in;
    word_t      cdb_result_in;

    logic       alu_full_in;
    logic       alu_calc_enable_out;
    calc_code_t alu_calc_code_out;
    word_t      alu_lhs_out;
    word_t      alu_rhs_out;
    iq_addr_t   alu_pos_in_iq_out;

    modport master (
        output rdy, update_stat, clear_flag_in,
        output issue_enable_in, issue_calc_code_in, issue_lhs_ready_in, issue_lhs_in,
               issue_lhs_tag_in, issue_rhs_ready_in, issue_rhs_in, issue_rhs_tag_in,
               issue_pos_in_iq_in,
        output cdb_enable_in, cdb_iq_idx_in, cdb_result_in, alu_full_in,
        input  full_out, alu_calc_enable_out, alu_calc_code_out, alu_lhs_out,
               alu_rhs_out, alu_pos_in_iq_out
    );

    modport slave (
        input  rdy, update_stat, clear_flag_in,
        input  issue_enable_in, issue_calc_code_in, issue_lhs_ready_in, issue_lhs_in,
               issue_lhs_tag_in, issue_rhs_ready_in, issue_rhs_in, issue_rhs_tag_in,
               issue_pos_in_iq_in,
        input  cdb_enable_in, cdb_iq_idx_in, cdb_result_in, alu_full_in,
        output full_out, alu_calc_enable_out, alu_calc_code_out, alu_lhs_out,
               alu_rhs_out, alu_pos_in_iq_out
    );

endinterface

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder: found flag plus index of the first set request bit.
module rs_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until both operands resolve, snoops the CDB,
// and dispatches the lowest-index ready op on each dispatch-phase edge.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE   = RS_SIZE_DEF,
    parameter int RS_ADDR_W = $clog2(RS_SIZE)
) (
    input logic   clk,
    input logic   rst,
    alu_rs_if.slave bus
);

    logic [RS_SIZE-1:0]   valid;
    logic [RS_SIZE-1:0]   ready_vec;
    rs_entry_t            ent [RS_SIZE];

    logic                 free_found, pick_found;
    logic [RS_ADDR_W-1:0] free_idx, pick_idx;
    logic                 full;
    rs_entry_t            new_ent;
    logic                 new_lhs_hit, new_rhs_hit;

    logic                 calc_en;
    calc_code_t           calc_code;
    word_t                calc_lhs, calc_rhs;
    iq_addr_t             calc_pos;

    for (genvar i = 0; i < RS_SIZE; i++) begin : g_ready
        assign ready_vec[i] = valid[i] & ent[i].lhs_rdy & ent[i].rhs_rdy;
    end

    rs_pick #(.N(RS_SIZE), .W(RS_ADDR_W)) u_free_pick (
        .req(~valid), .found(free_found), .idx(free_idx)
    );

    rs_pick #(.N(RS_SIZE), .W(RS_ADDR_W)) u_ready_pick (
        .req(ready_vec), .found(pick_found), .idx(pick_idx)
    );

    assign full = &valid;

    // Same-edge CDB bypass so an op whose producer is broadcasting now enters ready.
    assign new_lhs_hit = tag_hit(bus.issue_lhs_ready_in, bus.issue_lhs_tag_in,
                                 bus.cdb_enable_in, bus.cdb_iq_idx_in);
    assign new_rhs_hit = tag_hit(bus.issue_rhs_ready_in, bus.issue_rhs_tag_in,
                                 bus.cdb_enable_in, bus.cdb_iq_idx_in);

    always_comb begin
        new_ent         = '0;
        new_ent.code    = bus.issue_calc_code_in;
        new_ent.lhs     = new_lhs_hit ? bus.cdb_result_in : bus.issue_lhs_in;
        new_ent.rhs     = new_rhs_hit ? bus.cdb_result_in : bus.issue_rhs_in;
        new_ent.lhs_tag = bus.issue_lhs_tag_in;
        new_ent.rhs_tag = bus.issue_rhs_tag_in;
        new_ent.lhs_rdy = bus.issue_lhs_ready_in | new_lhs_hit;
        new_ent.rhs_rdy = bus.issue_rhs_ready_in | new_rhs_hit;
        new_ent.pos     = bus.issue_pos_in_iq_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= '0;
            calc_en   <= 1'b0;
            calc_code <= '0;
            calc_lhs  <= '0;
            calc_rhs  <= '0;
            calc_pos  <= '0;
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
        end else if (bus.rdy) begin
            if (bus.clear_flag_in) begin
                valid   <= '0;
                calc_en <= 1'b0;
            end else if (bus.update_stat) begin
                calc_en <= 1'b0;
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid[i]) begin
                        if (tag_hit(ent[i].lhs_rdy, ent[i].lhs_tag, bus.cdb_enable_in, bus.cdb_iq_idx_in)) begin
                            ent[i].lhs     <= bus.cdb_result_in;
                            ent[i].lhs_rdy <= 1'b1;
                        end
                        if (tag_hit(ent[i].rhs_rdy, ent[i].rhs_tag, bus.cdb_enable_in, bus.cdb_iq_idx_in)) begin
                            ent[i].rhs     <= bus.cdb_result_in;
                            ent[i].rhs_rdy <= 1'b1;
                        end
                    end
                end
                // The free slot is invalid, so the snoop loop above never targets it.
                if (bus.issue_enable_in && !full && free_found) begin
                    valid[free_idx] <= 1'b1;
                    ent[free_idx]   <= new_ent;
                end
            end else begin
                if (!bus.alu_full_in && pick_found) begin
                    calc_en         <= 1'b1;
                    calc_code       <= ent[pick_idx].code;
                    calc_lhs        <= ent[pick_idx].lhs;
                    calc_rhs        <= ent[pick_idx].rhs;
                    calc_pos        <= ent[pick_idx].pos;
                    valid[pick_idx] <= 1'b0;
                end else begin
                    calc_en <= 1'b0;
                end
            end
        end
    end

    assign bus.full_out            = full;
    assign bus.alu_calc_enable_out = calc_en;
    assign bus.alu_calc_code_out   = calc_code;
    assign bus.alu_lhs_out         = calc_lhs;
    assign bus.alu_rhs_out         = calc_rhs;
    assign bus.alu_pos_in_iq_out   = calc_pos;

endmodule

// File: tb/tb_alu_rs.sv
// Directed scenarios plus randomized traffic checked against a slot-list model of the RS.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_rs_if bus ();

    alu_rs #(.RS_SIZE(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a list of 8 slots, each an op with operands either known or awaiting a tag.
    bit         m_valid [8];
    calc_code_t m_code  [8];
    word_t      m_lhs   [8];
    word_t      m_rhs   [8];
    iq_addr_t   m_ltag  [8];
    iq_addr_t   m_rtag  [8];
    bit         m_lknown[8];
    bit         m_rknown[8];
    iq_addr_t   m_pos   [8];
    bit         m_en;
    calc_code_t m_code_o;
    word_t      m_lhs_o, m_rhs_o;
    iq_addr_t   m_pos_o;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        m_en = 0; m_code_o = '0; m_lhs_o = '0; m_rhs_o = '0; m_pos_o = '0;
    endtask

    task automatic model_edge();
        bit was_full;
        int slot;
        if (!bus.rdy) return;
        if (bus.clear_flag_in) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
            m_en = 0;
        end else if (bus.update_stat) begin
            was_full = (m_count() == 8);
            m_en = 0;
            if (bus.cdb_enable_in) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_valid[i] && !m_lknown[i] && m_ltag[i] == bus.cdb_iq_idx_in) begin
                        m_lhs[i] = bus.cdb_result_in; m_lknown[i] = 1;
                    end
                    if (m_valid[i] && !m_rknown[i] && m_rtag[i] == bus.cdb_iq_idx_in) begin
                        m_rhs[i] = bus.cdb_result_in; m_rknown[i] = 1;
                    end
                end
            end
            if (bus.issue_enable_in && !was_full) begin
                slot = -1;
                for (int i = 7; i >= 0; i--) if (!m_valid[i]) slot = i;
                m_valid[slot] = 1;
                m_code[slot]  = bus.issue_calc_code_in;
                m_ltag[slot]  = bus.issue_lhs_tag_in;
                m_rtag[slot]  = bus.issue_rhs_tag_in;
                m_pos[slot]   = bus.issue_pos_in_iq_in;
                m_lknown[slot] = bus.issue_lhs_ready_in;
                m_lhs[slot]    = bus.issue_lhs_in;
                if (!bus.issue_lhs_ready_in && bus.cdb_enable_in && bus.issue_lhs_tag_in == bus.cdb_iq_idx_in) begin
                    m_lknown[slot] = 1; m_lhs[slot] = bus.cdb_result_in;
                end
                m_rknown[slot] = bus.issue_rhs_ready_in;
                m_rhs[slot]    = bus.issue_rhs_in;
                if (!bus.issue_rhs_ready_in && bus.cdb_enable_in && bus.issue_rhs_tag_in == bus.cdb_iq_idx_in) begin
                    m_rknown[slot] = 1; m_rhs[slot] = bus.cdb_result_in;
                end
            end
        end else begin
            slot = -1;
            for (int i = 7; i >= 0; i--) if (m_valid[i] && m_lknown[i] && m_rknown[i]) slot = i;
            if (!bus.alu_full_in && slot >= 0) begin
                m_en = 1; m_code_o = m_code[slot]; m_lhs_o = m_lhs[slot];
                m_rhs_o = m_rhs[slot]; m_pos_o = m_pos[slot];
                m_valid[slot] = 0;
            end else begin
                m_en = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rdy = 1; bus.update_stat = 0; bus.clear_flag_in = 0;
        bus.issue_enable_in = 0; bus.issue_calc_code_in = '0;
        bus.issue_lhs_ready_in = 0; bus.issue_lhs_in = '0; bus.issue_lhs_tag_in = '0;
        bus.issue_rhs_ready_in = 0; bus.issue_rhs_in = '0; bus.issue_rhs_tag_in = '0;
        bus.issue_pos_in_iq_in = '0;
        bus.cdb_enable_in = 0; bus.cdb_iq_idx_in = '0; bus.cdb_result_in = '0;
        bus.alu_full_in = 0;
    endtask

    task automatic issue_op(input calc_code_t code, input bit lr, input word_t l, input iq_addr_t lt,
                            input bit rr, input word_t r, input iq_addr_t rt, input iq_addr_t pos);
        bus.issue_enable_in = 1; bus.issue_calc_code_in = code;
        bus.issue_lhs_ready_in = lr; bus.issue_lhs_in = l; bus.issue_lhs_tag_in = lt;
        bus.issue_rhs_ready_in = rr; bus.issue_rhs_in = r; bus.issue_rhs_tag_in = rt;
        bus.issue_pos_in_iq_in = pos;
    endtask

    task automatic accept_edge();
        bus.update_stat = 1;
        tick();
        bus.issue_enable_in = 0; bus.cdb_enable_in = 0;
    endtask

    task automatic dispatch_edge(input bit af);
        bus.update_stat = 0; bus.alu_full_in = af;
        tick();
        bus.alu_full_in = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #2;
        checks++;
        if ({bus.alu_calc_enable_out, bus.alu_calc_code_out, bus.alu_lhs_out, bus.alu_rhs_out,
             bus.alu_pos_in_iq_out, bus.full_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b code=%h lhs=%h rhs=%h pos=%h full=%b, required all zero",
                     bus.alu_calc_enable_out, bus.alu_calc_code_out, bus.alu_lhs_out,
                     bus.alu_rhs_out, bus.alu_pos_in_iq_out, bus.full_out);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic_dispatch();
        issue_op(4'd0, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0, 4'd3);
        accept_edge();
        checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin
            errors++; $display("FAIL basic_early: en=%b, required 0", bus.alu_calc_enable_out);
        end
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_calc_code_out !== 4'd0 || bus.alu_lhs_out !== 32'd5 ||
            bus.alu_rhs_out !== 32'd7 || bus.alu_pos_in_iq_out !== 4'd3) begin
            errors++;
            $display("FAIL basic_dispatch: en=%b code=%0d lhs=%0d rhs=%0d pos=%0d, required 1 0 5 7 3",
                     bus.alu_calc_enable_out, bus.alu_calc_code_out, bus.alu_lhs_out,
                     bus.alu_rhs_out, bus.alu_pos_in_iq_out);
        end
        accept_edge();
        checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin
            errors++; $display("FAIL basic_one_cycle: en=%b, required 0", bus.alu_calc_enable_out);
        end
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin
            errors++; $display("FAIL basic_empty: en=%b, required 0", bus.alu_calc_enable_out);
        end
    endtask

    task automatic test_cdb_wakeup();
        issue_op(4'd3, 1, 32'd1, 4'd0, 0, 32'd0, 4'd6, 4'd4);
        accept_edge();
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin
            errors++; $display("FAIL wakeup_early: en=%b, required 0", bus.alu_calc_enable_out);
        end
        bus.cdb_enable_in = 1; bus.cdb_iq_idx_in = 4'd6; bus.cdb_result_in = 32'h10;
        accept_edge();
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_calc_code_out !== 4'd3 || bus.alu_lhs_out !== 32'd1 ||
            bus.alu_rhs_out !== 32'h10 || bus.alu_pos_in_iq_out !== 4'd4) begin
            errors++;
            $display("FAIL wakeup_dispatch: en=%b code=%0d lhs=%h rhs=%h pos=%0d, required 1 3 1 10 4",
                     bus.alu_calc_enable_out, bus.alu_calc_code_out, bus.alu_lhs_out,
                     bus.alu_rhs_out, bus.alu_pos_in_iq_out);
        end
    endtask

    task automatic test_bypass();
        issue_op(4'd5, 0, 32'd0, 4'd2, 1, 32'd9, 4'd0, 4'd7);
        bus.cdb_enable_in = 1; bus.cdb_iq_idx_in = 4'd2; bus.cdb_result_in = 32'hAA;
        accept_edge();
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_lhs_out !== 32'hAA ||
            bus.alu_rhs_out !== 32'd9 || bus.alu_pos_in_iq_out !== 4'd7) begin
            errors++;
            $display("FAIL bypass: en=%b lhs=%h rhs=%h pos=%0d, required 1 aa 9 7",
                     bus.alu_calc_enable_out, bus.alu_lhs_out, bus.alu_rhs_out, bus.alu_pos_in_iq_out);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            issue_op(calc_code_t'(i), 1, word_t'(100 + i), 4'd0, 1, word_t'(200 + i), 4'd0, iq_addr_t'(i));
            accept_edge();
            dispatch_edge(1);
        end
        checks++;
        if (bus.full_out !== 1'b1) begin
            errors++; $display("FAIL full_set: full=%b, required 1", bus.full_out);
        end
        issue_op(4'd9, 1, 32'd999, 4'd0, 1, 32'd999, 4'd0, 4'd15);
        accept_edge();
        checks++;
        if (bus.full_out !== 1'b1) begin
            errors++; $display("FAIL full_drop: full=%b, required 1", bus.full_out);
        end
        dispatch_edge(0);
        checks++;
        if (bus.full_out !== 1'b0 || bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== 4'd0) begin
            errors++;
            $display("FAIL full_release: full=%b en=%b pos=%0d, required 0 1 0",
                     bus.full_out, bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
        for (int i = 1; i < 8; i++) begin
            accept_edge();
            dispatch_edge(0);
            checks++;
            if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== iq_addr_t'(i) ||
                bus.alu_lhs_out !== word_t'(100 + i)) begin
                errors++;
                $display("FAIL full_drain_%0d: en=%b pos=%0d lhs=%0d, required 1 %0d %0d",
                         i, bus.alu_calc_enable_out, bus.alu_pos_in_iq_out, bus.alu_lhs_out, i, 100 + i);
            end
        end
        accept_edge();
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin
            errors++; $display("FAIL full_dropped_op_seen: en=%b pos=%0d, required en 0",
                               bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
    endtask

    task automatic test_alu_full();
        issue_op(4'd1, 1, 32'd10, 4'd0, 1, 32'd11, 4'd0, 4'd10);
        accept_edge();
        dispatch_edge(1);
        issue_op(4'd2, 1, 32'd20, 4'd0, 1, 32'd21, 4'd0, 4'd11);
        accept_edge();
        dispatch_edge(1);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin
            errors++; $display("FAIL alu_full_block: en=%b, required 0", bus.alu_calc_enable_out);
        end
        accept_edge();
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== 4'd10) begin
            errors++; $display("FAIL alu_full_first: en=%b pos=%0d, required 1 10",
                               bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
        accept_edge();
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== 4'd11) begin
            errors++; $display("FAIL alu_full_second: en=%b pos=%0d, required 1 11",
                               bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
    endtask

    task automatic test_clear_rst();
        for (int i = 0; i < 5; i++) begin
            issue_op(4'd4, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0, iq_addr_t'(i + 1));
            accept_edge();
            if (i < 4) dispatch_edge(1);
        end
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b1 || bus.alu_pos_in_iq_out !== 4'd1) begin
            errors++; $display("FAIL clear_setup: en=%b pos=%0d, required 1 1",
                               bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
        bus.clear_flag_in = 1;
        issue_op(4'd6, 1, 32'd3, 4'd0, 1, 32'd4, 4'd0, 4'd12);
        bus.cdb_enable_in = 1; bus.cdb_iq_idx_in = 4'd1; bus.cdb_result_in = 32'h55;
        accept_edge();
        bus.clear_flag_in = 0;
        checks++;
        if (bus.alu_calc_enable_out !== 1'b0 || bus.full_out !== 1'b0) begin
            errors++; $display("FAIL clear_en: en=%b full=%b, required 0 0",
                               bus.alu_calc_enable_out, bus.full_out);
        end
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin
            errors++; $display("FAIL clear_empty: en=%b pos=%0d, required en 0",
                               bus.alu_calc_enable_out, bus.alu_pos_in_iq_out);
        end
        issue_op(4'd7, 1, 32'd8, 4'd0, 1, 32'd9, 4'd0, 4'd13);
        accept_edge();
        #2 rst = 1;
        #1;
        checks++;
        if ({bus.alu_calc_enable_out, bus.alu_calc_code_out, bus.alu_lhs_out, bus.alu_rhs_out,
             bus.alu_pos_in_iq_out, bus.full_out} !== '0) begin
            errors++;
            $display("FAIL async_rst: en=%b code=%h lhs=%h rhs=%h pos=%h full=%b, required all zero",
                     bus.alu_calc_enable_out, bus.alu_calc_code_out, bus.alu_lhs_out,
                     bus.alu_rhs_out, bus.alu_pos_in_iq_out, bus.full_out);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
        dispatch_edge(0);
        checks++;
        if (bus.alu_calc_enable_out !== 1'b0) begin
            errors++; $display("FAIL rst_empty: en=%b, required 0", bus.alu_calc_enable_out);
        end
    endtask

    task automatic test_random();
        bit ph = 1;
        for (int n = 0; n < 800; n++) begin
            bus.rdy           = ($urandom_range(0, 9) != 0);
            bus.clear_flag_in = ($urandom_range(0, 59) == 0);
            bus.update_stat   = ph;
            bus.issue_enable_in    = ($urandom_range(0, 1) == 1) && (m_count() < 8 || $urandom_range(0, 7) == 0);
            bus.issue_calc_code_in = calc_code_t'($urandom);
            bus.issue_lhs_ready_in = $urandom_range(0, 1) == 1;
            bus.issue_lhs_in       = $urandom;
            bus.issue_lhs_tag_in   = iq_addr_t'($urandom_range(0, 3));
            bus.issue_rhs_ready_in = $urandom_range(0, 1) == 1;
            bus.issue_rhs_in       = $urandom;
            bus.issue_rhs_tag_in   = iq_addr_t'($urandom_range(0, 3));
            bus.issue_pos_in_iq_in = iq_addr_t'($urandom);
            bus.cdb_enable_in      = $urandom_range(0, 1) == 1;
            bus.cdb_iq_idx_in      = iq_addr_t'($urandom_range(0, 4));
            bus.cdb_result_in      = $urandom;
            bus.alu_full_in        = ($urandom_range(0, 3) == 0);
            tick();
            if (bus.rdy) ph = ~ph;
            checks++;
            if (bus.alu_calc_enable_out !== m_en || bus.alu_calc_code_out !== m_code_o ||
                bus.alu_lhs_out !== m_lhs_o || bus.alu_rhs_out !== m_rhs_o ||
                bus.alu_pos_in_iq_out !== m_pos_o || bus.full_out !== (m_count() == 8)) begin
                errors++;
                $display("FAIL random_%0d: en=%b code=%h lhs=%h rhs=%h pos=%h full=%b, required en=%b code=%h lhs=%h rhs=%h pos=%h full=%b",
                         n, bus.alu_calc_enable_out, bus.alu_calc_code_out, bus.alu_lhs_out,
                         bus.alu_rhs_out, bus.alu_pos_in_iq_out, bus.full_out,
                         m_en, m_code_o, m_lhs_o, m_rhs_o, m_pos_o, m_count() == 8);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_dispatch();
        test_cdb_wakeup();
        test_bypass();
        test_full();
        test_alu_full();
        test_clear_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
